nibble_sram_ctrl: RTL and testbench

Parametrised nibble-serial SRAM controller: the next generation of the team's shared-bus byte SRAM. Address and data arrive serially over a narrow input bus, a few bits per beat, with separate command and valid lines instead of in-band enables. The block supports arbitrary word/address widths and non-power-of-two depth. Streaming starts at a programmable pointer and wraps at DEPTH. Mid-sequence command changes abort cleanly and raise a sticky error flag. The block sits behind the pin-muxing wrapper, with all I/O unidirectional.

---
 rtl/nibble_sram_ctrl.sv | 227 ++++++++++++++++++++++
 tb/tb_nibble_sram_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_sram_ctrl.sv
// nibble_sram_ctrl: nibble-serial SRAM controller.
// Words and addresses arrive LS nibble first over a narrow bus, one nibble per
// beat (in_valid=1). cmd selects WRITE (NB data + AB address beats), READ
// (AB address beats) or STREAM (one word per beat from ptr, wrapping at DEPTH).
// Ports:
//   clk, rst        clock, async active-low reset
//   cmd, in_valid   command (sampled on beats) and beat qualifier
//   bus_in          beat payload
//   rd_data         last word read (registered), rd_valid one-cycle pulse per word
//   ptr             stream pointer, busy sequence in progress, err sticky error
module nibble_sram_ctrl #(
  parameter int unsigned AW    = 4,
  parameter int unsigned DW    = 8,
  parameter int unsigned NW    = 4,
  parameter int unsigned DEPTH = 1 << AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    cmd,
  input  logic          in_valid,
  input  logic [NW-1:0] bus_in,
  output logic [DW-1:0] rd_data,
  output logic          rd_valid,
  output logic [AW-1:0] ptr,
  output logic          busy,
  output logic          err
);

  localparam int unsigned NB  = DW / NW;
  localparam int unsigned AB  = (AW + NW - 1) / NW;
  localparam int unsigned ABW = AB * NW;
  localparam int unsigned MB  = (NB > AB) ? NB : AB;
  localparam int unsigned CW  = $clog2(MB + 1);

  localparam logic [1:0] CmdIdle   = 2'b00;
  localparam logic [1:0] CmdWrite  = 2'b01;
  localparam logic [1:0] CmdRead   = 2'b10;
  localparam logic [1:0] CmdStream = 2'b11;

  typedef enum logic [1:0] {StIdle, StWrData, StWrAddr, StRdAddr} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]   word_q, word_d;
  logic [ABW-1:0]  addr_q, addr_d;
  logic [AW-1:0]   ptr_q, ptr_d;
  logic [DW-1:0]   rd_data_q, rd_data_d;
  logic            rd_valid_q, rd_valid_d;
  logic            err_q, err_d;
  logic            live_q;

  logic [DW-1:0]   mem [DEPTH];

  logic            beat;
  logic [DW-1:0]   word_next;
  logic [ABW-1:0]  addr_next;
  logic [AW-1:0]   addr_fin;
  logic            in_range;
  logic            rd_fire, wr_fire, mem_we;

  function automatic logic [AW-1:0] wrap_inc(input logic [AW-1:0] a);
    return (32'(a) == DEPTH - 1) ? '0 : a + AW'(1);
  endfunction

  // live_q masks the first edge after reset release so no beat is taken there.
  assign beat      = in_valid & live_q;
  // Shift registers filled LS nibble first: after the last beat the value is aligned.
  assign word_next = (word_q >> NW) | (DW'(bus_in) << (DW - NW));
  assign addr_next = (addr_q >> NW) | (ABW'(bus_in) << (ABW - NW));
  assign addr_fin  = addr_next[AW-1:0];
  assign in_range  = 32'(addr_fin) < DEPTH;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    word_d     = word_q;
    addr_d     = addr_q;
    ptr_d      = ptr_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    err_d      = err_q;
    rd_fire    = 1'b0;
    wr_fire    = 1'b0;
    mem_we     = 1'b0;

    if (beat) begin
      unique case (state_q)
        StIdle: begin
          unique case (cmd)
            CmdWrite: begin
              word_d = word_next;
              if (NB == 1) begin
                state_d = StWrAddr;
                cnt_d   = '0;
              end else begin
                state_d = StWrData;
                cnt_d   = CW'(1);
              end
            end
            CmdRead: begin
              addr_d = addr_next;
              if (AB == 1) begin
                rd_fire = 1'b1;
              end else begin
                state_d = StRdAddr;
                cnt_d   = CW'(1);
              end
            end
            CmdStream: begin
              rd_data_d  = mem[ptr_q];
              rd_valid_d = 1'b1;
              ptr_d      = wrap_inc(ptr_q);
            end
            CmdIdle: ;
            default: ;
          endcase
        end
        StWrData: begin
          if (cmd != CmdWrite) begin
            state_d = StIdle;
            cnt_d   = '0;
            err_d   = 1'b1;
          end else begin
            word_d = word_next;
            if (cnt_q == CW'(NB - 1)) begin
              state_d = StWrAddr;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
        end
        StWrAddr: begin
          if (cmd != CmdWrite) begin
            state_d = StIdle;
            cnt_d   = '0;
            err_d   = 1'b1;
          end else begin
            addr_d = addr_next;
            if (cnt_q == CW'(AB - 1)) begin
              wr_fire = 1'b1;
              state_d = StIdle;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
        end
        StRdAddr: begin
          if (cmd != CmdRead) begin
            state_d = StIdle;
            cnt_d   = '0;
            err_d   = 1'b1;
          end else begin
            addr_d = addr_next;
            if (cnt_q == CW'(AB - 1)) begin
              rd_fire = 1'b1;
              state_d = StIdle;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end

    if (rd_fire) begin
      rd_valid_d = 1'b1;
      if (in_range) begin
        rd_data_d = mem[addr_fin];
        ptr_d     = wrap_inc(addr_fin);
      end else begin
        rd_data_d = '0;
        err_d     = 1'b1;
      end
    end

    if (wr_fire) begin
      if (in_range) begin
        mem_we = 1'b1;
        ptr_d  = wrap_inc(addr_fin);
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      word_q     <= '0;
      addr_q     <= '0;
      ptr_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      err_q      <= 1'b0;
      live_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      word_q     <= word_d;
      addr_q     <= addr_d;
      ptr_q      <= ptr_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      err_q      <= err_d;
      live_q     <= 1'b1;
    end
  end

  // Memory is deliberately unreset so contents survive rst.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[addr_fin] <= word_q;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign ptr      = ptr_q;
  assign busy     = (state_q != StIdle);
  assign err      = err_q;

endmodule

// File: tb/tb_nibble_sram_ctrl.sv
// Directed bench for nibble_sram_ctrl: default instance (DEPTH=16) and a
// DEPTH=12 instance sharing cmd/bus_in/rst with separate beat qualifiers.
module tb_nibble_sram_ctrl;

  localparam logic [1:0] CI = 2'b00;
  localparam logic [1:0] CW = 2'b01;
  localparam logic [1:0] CR = 2'b10;
  localparam logic [1:0] CS = 2'b11;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] cmd = 2'b00;
  logic [3:0] bus_in = 4'h0;
  logic       vld = 1'b0;
  logic       tgt = 1'b0;
  logic       in_valid_a, in_valid_b;

  logic [7:0] rd_data_a, rd_data_b;
  logic       rd_valid_a, rd_valid_b;
  logic [3:0] ptr_a, ptr_b;
  logic       busy_a, busy_b;
  logic       err_a, err_b;

  int total = 0;
  int bad   = 0;

  assign in_valid_a = vld & ~tgt;
  assign in_valid_b = vld & tgt;

  always #5 clk = ~clk;

  nibble_sram_ctrl u_dut_a (
    .clk      (clk),
    .rst      (rst),
    .cmd      (cmd),
    .in_valid (in_valid_a),
    .bus_in   (bus_in),
    .rd_data  (rd_data_a),
    .rd_valid (rd_valid_a),
    .ptr      (ptr_a),
    .busy     (busy_a),
    .err      (err_a)
  );

  nibble_sram_ctrl #(.DEPTH(12)) u_dut_b (
    .clk      (clk),
    .rst      (rst),
    .cmd      (cmd),
    .in_valid (in_valid_b),
    .bus_in   (bus_in),
    .rd_data  (rd_data_b),
    .rd_valid (rd_valid_b),
    .ptr      (ptr_b),
    .busy     (busy_b),
    .err      (err_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // Drive one beat from the falling edge; it stays asserted until the next call.
  task automatic beat(input logic [1:0] c, input logic [3:0] n);
    @(negedge clk);
    cmd    = c;
    bus_in = n;
    vld    = 1'b1;
  endtask

  task automatic idle();
    @(negedge clk);
    vld = 1'b0;
  endtask

  task automatic write_word(input logic [7:0] d, input logic [3:0] a);
    beat(CW, d[3:0]);
    beat(CW, d[7:4]);
    beat(CW, a);
    idle();
  endtask

  task automatic read_addr(input logic [3:0] a);
    beat(CR, a);
    idle();
  endtask

  initial begin
    // Reset state
    #3;
    check("rst_rd_data", rd_data_a, 0);
    check("rst_rd_valid", rd_valid_a, 0);
    check("rst_ptr", ptr_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_err", err_a, 0);
    check("rst_err_b", err_b, 0);
    @(negedge clk);
    rst = 1'b1;
    idle();

    // 1: write 0xA5 @3, read back
    beat(CW, 4'h5);
    beat(CW, 4'hA);
    check("s1_busy_mid", busy_a, 1);
    beat(CW, 4'h3);
    idle();
    check("s1_busy_done", busy_a, 0);
    check("s1_ptr_wr", ptr_a, 4);
    check("s1_err", err_a, 0);
    read_addr(4'h3);
    check("s1_rd_data", rd_data_a, 8'hA5);
    check("s1_rd_valid", rd_valid_a, 1);
    check("s1_ptr_rd", ptr_a, 4);
    idle();
    check("s1_rd_valid_pulse", rd_valid_a, 0);
    check("s1_rd_data_hold", rd_data_a, 8'hA5);

    // 2: stream across the wrap point
    write_word(8'h11, 4'hE);
    write_word(8'h22, 4'hF);
    write_word(8'h33, 4'h0);
    check("s2_ptr_wr", ptr_a, 1);
    read_addr(4'hD);
    check("s2_ptr_rd", ptr_a, 4'hE);
    beat(CS, 4'h0);
    beat(CS, 4'h7);
    check("s2_st0_data", rd_data_a, 8'h11);
    check("s2_st0_valid", rd_valid_a, 1);
    check("s2_st0_ptr", ptr_a, 4'hF);
    beat(CS, 4'h9);
    check("s2_st1_data", rd_data_a, 8'h22);
    check("s2_st1_valid", rd_valid_a, 1);
    check("s2_st1_ptr", ptr_a, 0);
    idle();
    check("s2_st2_data", rd_data_a, 8'h33);
    check("s2_st2_valid", rd_valid_a, 1);
    check("s2_st2_ptr", ptr_a, 1);
    idle();
    check("s2_st_end", rd_valid_a, 0);

    // 3: abort a write with a read beat
    beat(CW, 4'h5);
    beat(CW, 4'hA);
    beat(CR, 4'h3);
    idle();
    check("s3_err", err_a, 1);
    check("s3_busy", busy_a, 0);
    check("s3_no_rv", rd_valid_a, 0);
    check("s3_ptr", ptr_a, 1);
    read_addr(4'h3);
    check("s3_old_data", rd_data_a, 8'hA5);
    check("s3_rv", rd_valid_a, 1);

    // 4: write 0x69 @3 with gaps between beats
    beat(CW, 4'h9);
    repeat (3) idle();
    check("s4_busy_gap0", busy_a, 1);
    beat(CW, 4'h6);
    repeat (3) idle();
    check("s4_busy_gap1", busy_a, 1);
    beat(CW, 4'h3);
    idle();
    check("s4_busy_done", busy_a, 0);
    check("s4_ptr", ptr_a, 4);
    read_addr(4'h3);
    check("s4_rd_data", rd_data_a, 8'h69);
    check("s4_err_sticky", err_a, 1);

    // 5: async reset mid-write, memory survives
    beat(CW, 4'h5);
    beat(CW, 4'hA);
    idle();
    check("s5_busy_pre", busy_a, 1);
    #2 rst = 1'b0;
    #1;
    check("s5_rst_busy", busy_a, 0);
    check("s5_rst_err", err_a, 0);
    check("s5_rst_data", rd_data_a, 0);
    check("s5_rst_ptr", ptr_a, 0);
    @(negedge clk);
    rst = 1'b1;
    idle();
    write_word(8'hC7, 4'h2);
    check("s5_ptr_wr", ptr_a, 3);
    read_addr(4'h2);
    check("s5_rd_data", rd_data_a, 8'hC7);
    check("s5_err", err_a, 0);
    read_addr(4'h3);
    check("s5_mem_kept", rd_data_a, 8'h69);
    beat(CI, 4'h0);
    idle();
    check("s5_idle_err", err_a, 0);
    check("s5_idle_rv", rd_valid_a, 0);

    // 6: DEPTH=12 instance, out-of-range accesses and wrap at 11
    tgt = 1'b1;
    write_word(8'h55, 4'hB);
    check("s6_ptr_wr11", ptr_b, 0);
    write_word(8'h44, 4'hA);
    check("s6_ptr_wr10", ptr_b, 4'hB);
    check("s6_err_ok", err_b, 0);
    write_word(8'h11, 4'hD);
    check("s6_oor_err", err_b, 1);
    check("s6_oor_ptr", ptr_b, 4'hB);
    beat(CS, 4'h0);
    idle();
    check("s6_st_data", rd_data_b, 8'h55);
    check("s6_st_valid", rd_valid_b, 1);
    check("s6_st_wrap", ptr_b, 0);
    read_addr(4'hE);
    check("s6_oor_rd_data", rd_data_b, 0);
    check("s6_oor_rd_valid", rd_valid_b, 1);
    check("s6_oor_rd_ptr", ptr_b, 0);
    read_addr(4'hA);
    check("s6_rd10", rd_data_b, 8'h44);
    check("s6_rd10_ptr", ptr_b, 4'hB);
    check("s6_a_untouched", ptr_a, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
